board_input_conditioner: RTL and testbench

Board-level input conditioning block for the FPGA top levels, sitting between raw board pins and the chip-under-test wrapper. It generalises the plain combination of lock and reset button and the bare button inversion to N buttons. Each button is synchronised, debounced and polarity-normalised, with one-cycle press and release strobes. A state-machine reset sequencer releases the core reset only after PLL lock is stable, the reset button is released and a programmable hold time has elapsed.

---
 rtl/board_io_pkg.sv | 29 ++
 rtl/debounce_channel.sv | 61 ++++++
 rtl/board_input_conditioner.sv | 116 +++++++++++
 tb/tb_board_input_conditioner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// -----------------------------------------------------------------------------
// board_io_pkg
// Shared types and constants for the board input conditioner.
//   rst_seq_state_t : reset sequencer states
//   DEF_*           : default parameter values used by the top level
//   cnt_width()     : counter width for a terminal count n (at least 1 bit)
// -----------------------------------------------------------------------------
package board_io_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } rst_seq_state_t;

   localparam int DEF_NUM_BTN         = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 1260000;  // 10 ms at 126 MHz
   localparam int DEF_SYNC_STAGES     = 2;
   localparam bit DEF_ACTIVE_LOW      = 1'b1;
   localparam int DEF_RST_HOLD_CYCLES = 16;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One input bit: polarity normalisation, synchroniser chain, debounce counter
// and one-cycle edge strobes.
//   clk, rst        : clock, asynchronous active-high reset
//   raw             : raw (asynchronous) pin
//   level           : debounced state, 1 = pressed
//   press_strobe    : one cycle, coincident with level 0->1
//   release_strobe  : one cycle, coincident with level 1->0
// -----------------------------------------------------------------------------
module debounce_channel
   import board_io_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press_strobe,
   output logic release_strobe
);

   localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   s;

   // Oldest stage of the chain is the clean sample.
   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync           <= '0;
         cnt            <= '0;
         level          <= 1'b0;
         press_strobe   <= 1'b0;
         release_strobe <= 1'b0;
      end else begin
         // Inverting before the chain makes "pressed" read 1 everywhere inside.
         sync           <= {sync[SYNC_STAGES-2:0], raw ^ ACTIVE_LOW};
         press_strobe   <= 1'b0;
         release_strobe <= 1'b0;
         if (s == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level          <= s;
            cnt            <= '0;
            press_strobe   <= s;
            release_strobe <= ~s;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/board_input_conditioner.sv
// -----------------------------------------------------------------------------
// board_input_conditioner
// Conditions NUM_BTN general buttons plus a reset button, and sequences the
// core reset from PLL lock.
//   clk, rst        : PLL clock, asynchronous active-high reset
//   pll_locked      : PLL lock (asynchronous)
//   rst_btn_raw     : raw reset button pin
//   btn_raw         : raw button pins
//   btn_level       : debounced button state, 1 = pressed
//   btn_press       : one-cycle strobe per accepted press
//   btn_release     : one-cycle strobe per accepted release
//   core_rst_n      : registered active-low core reset
//   lock_loss_cnt   : saturating count of lock losses seen in RUN
// -----------------------------------------------------------------------------
module board_input_conditioner
   import board_io_pkg::*;
#(
   parameter int NUM_BTN         = DEF_NUM_BTN,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW,
   parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               rst_btn_raw,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic               core_rst_n,
   output logic [7:0]         lock_loss_cnt
);

   localparam int            HW        = cnt_width(RST_HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

   // Channel NUM_BTN is the reset button; the rest map straight to outputs.
   logic [NUM_BTN:0] raw_all;
   logic [NUM_BTN:0] level_all;
   logic [NUM_BTN:0] press_all;
   logic [NUM_BTN:0] release_all;
   logic             rb;
   logic             rb_strobes_unused;

   assign raw_all = {rst_btn_raw, btn_raw};

   for (genvar i = 0; i <= NUM_BTN; i++) begin : g_chan
      debounce_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .raw           (raw_all[i]),
         .level         (level_all[i]),
         .press_strobe  (press_all[i]),
         .release_strobe(release_all[i])
      );
   end

   assign btn_level         = level_all[NUM_BTN-1:0];
   assign btn_press         = press_all[NUM_BTN-1:0];
   assign btn_release       = release_all[NUM_BTN-1:0];
   assign rb                = level_all[NUM_BTN];
   // The reset button only needs its level; its strobes are intentionally dropped.
   assign rb_strobes_unused = press_all[NUM_BTN] | release_all[NUM_BTN];

   // Lock synchroniser: no polarity inversion, clears to "not locked".
   logic [SYNC_STAGES-1:0] lock_sync;
   logic                   lock;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lock_sync <= '0;
      else     lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
   end
   assign lock = lock_sync[SYNC_STAGES-1];

   // Reset sequencer
   rst_seq_state_t state_q, state_d;
   logic [HW-1:0]  hcnt;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAIT_LOCK: if (lock && !rb) state_d = HOLD;
         HOLD: begin
            if (!lock || rb)              state_d = WAIT_LOCK;
            else if (hcnt == HOLD_LAST)   state_d = RUN;
         end
         RUN:       if (!lock || rb) state_d = WAIT_LOCK;
         default:   state_d = WAIT_LOCK;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= WAIT_LOCK;
         hcnt          <= '0;
         core_rst_n    <= 1'b0;
         lock_loss_cnt <= '0;
      end else begin
         state_q <= state_d;
         // hcnt only runs while staying in HOLD, so every entry starts at 0.
         hcnt    <= (state_q == HOLD && state_d == HOLD) ? hcnt + 1'b1 : '0;
         // Decoded from the next state so the reset output is a clean flop.
         core_rst_n <= (state_d == RUN);
         // A lock loss in RUN counts once even if the reset button is also down.
         if (state_q == RUN && !lock && lock_loss_cnt != 8'hFF)
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_board_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_board_input_conditioner
// Directed bench for board_input_conditioner with DEBOUNCE_CYCLES=8,
// SYNC_STAGES=2, RST_HOLD_CYCLES=4, ACTIVE_LOW=1, NUM_BTN=2.
// Inputs change #1 after a rising edge ("driven at edge k"); outputs are
// sampled #1 after an edge, so they show what that edge loaded.
// -----------------------------------------------------------------------------
module tb_board_input_conditioner;

   localparam int NUM_BTN = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               pll_locked;
   logic               rst_btn_raw;
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic               core_rst_n;
   logic [7:0]         lock_loss_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   board_input_conditioner #(
      .NUM_BTN        (NUM_BTN),
      .DEBOUNCE_CYCLES(8),
      .SYNC_STAGES    (2),
      .ACTIVE_LOW     (1'b1),
      .RST_HOLD_CYCLES(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .rst_btn_raw  (rst_btn_raw),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .btn_press    (btn_press),
      .btn_release  (btn_release),
      .core_rst_n   (core_rst_n),
      .lock_loss_cnt(lock_loss_cnt)
   );

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; pll_locked = 1'b0; rst_btn_raw = 1'b1; btn_raw = '1;
      step(3);
      tests_run++; if (btn_level !== 2'b00) begin tests_failed++; $display("FAIL reset_level: got %b expected 00", btn_level); end
      tests_run++; if (btn_press !== 2'b00 || btn_release !== 2'b00) begin tests_failed++; $display("FAIL reset_strobes: got %b/%b expected 00/00", btn_press, btn_release); end
      tests_run++; if (core_rst_n !== 1'b0) begin tests_failed++; $display("FAIL reset_core_rst_n: got %b expected 0", core_rst_n); end
      tests_run++; if (lock_loss_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_lock_loss: got %0d expected 0", lock_loss_cnt); end
      rst = 1'b0;
      step(1);
      // lock driven at edge k -> core_rst_n rises at k+2+1+4
      pll_locked = 1'b1;
      step(6);
      tests_run++; if (core_rst_n !== 1'b0) begin tests_failed++; $display("FAIL powerup_early: got %b expected 0", core_rst_n); end
      step(1);
      tests_run++; if (core_rst_n !== 1'b1) begin tests_failed++; $display("FAIL powerup_rise: got %b expected 1", core_rst_n); end
      step(5);
      tests_run++; if (core_rst_n !== 1'b1) begin tests_failed++; $display("FAIL powerup_stay: got %b expected 1", core_rst_n); end
   endtask

   task automatic test_clean_press();
      btn_raw[0] = 1'b0;
      step(9);
      tests_run++; if (btn_level !== 2'b00 || btn_press !== 2'b00) begin tests_failed++; $display("FAIL press_early: got level %b press %b expected 00/00", btn_level, btn_press); end
      step(1);
      tests_run++; if (btn_level !== 2'b01 || btn_press !== 2'b01 || btn_release !== 2'b00) begin tests_failed++; $display("FAIL press_accept: got level %b press %b rel %b expected 01/01/00", btn_level, btn_press, btn_release); end
      step(1);
      tests_run++; if (btn_level !== 2'b01 || btn_press !== 2'b00) begin tests_failed++; $display("FAIL press_width: got level %b press %b expected 01/00", btn_level, btn_press); end
      btn_raw[0] = 1'b1;
      step(9);
      tests_run++; if (btn_level !== 2'b01 || btn_release !== 2'b00) begin tests_failed++; $display("FAIL release_early: got level %b rel %b expected 01/00", btn_level, btn_release); end
      step(1);
      tests_run++; if (btn_level !== 2'b00 || btn_release !== 2'b01 || btn_press !== 2'b00) begin tests_failed++; $display("FAIL release_accept: got level %b rel %b press %b expected 00/01/00", btn_level, btn_release, btn_press); end
      step(1);
      tests_run++; if (btn_release !== 2'b00) begin tests_failed++; $display("FAIL release_width: got %b expected 00", btn_release); end
   endtask

   task automatic test_glitch();
      int bad;
      // 7-cycle pulse must vanish
      btn_raw[1] = 1'b0;
      step(7);
      btn_raw[1] = 1'b1;
      bad = 0;
      for (int i = 0; i < 14; i++) begin
         step(1);
         if (btn_level !== 2'b00 || btn_press !== 2'b00 || btn_release !== 2'b00) bad++;
      end
      tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL glitch_7: got %0d disturbed cycles expected 0", bad); end
      // 8-cycle pulse is accepted, then released 8 cycles after it ends
      btn_raw[1] = 1'b0;
      step(8);
      btn_raw[1] = 1'b1;
      step(1);
      tests_run++; if (btn_level !== 2'b00) begin tests_failed++; $display("FAIL glitch_8_early: got %b expected 00", btn_level); end
      step(1);
      tests_run++; if (btn_level !== 2'b10 || btn_press !== 2'b10) begin tests_failed++; $display("FAIL glitch_8_press: got level %b press %b expected 10/10", btn_level, btn_press); end
      step(7);
      tests_run++; if (btn_level !== 2'b10 || btn_release !== 2'b00) begin tests_failed++; $display("FAIL glitch_8_hold: got level %b rel %b expected 10/00", btn_level, btn_release); end
      step(1);
      tests_run++; if (btn_level !== 2'b00 || btn_release !== 2'b10) begin tests_failed++; $display("FAIL glitch_8_release: got level %b rel %b expected 00/10", btn_level, btn_release); end
      step(2);
   endtask

   task automatic test_lock_loss();
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(1);
      tests_run++; if (core_rst_n !== 1'b1) begin tests_failed++; $display("FAIL lock_drop_early: got %b expected 1", core_rst_n); end
      step(1);
      tests_run++; if (core_rst_n !== 1'b0 || lock_loss_cnt !== 8'd1) begin tests_failed++; $display("FAIL lock_drop: got rst_n %b cnt %0d expected 0/1", core_rst_n, lock_loss_cnt); end
      step(4);
      tests_run++; if (core_rst_n !== 1'b0) begin tests_failed++; $display("FAIL lock_restore_early: got %b expected 0", core_rst_n); end
      step(1);
      tests_run++; if (core_rst_n !== 1'b1 || lock_loss_cnt !== 8'd1) begin tests_failed++; $display("FAIL lock_restore: got rst_n %b cnt %0d expected 1/1", core_rst_n, lock_loss_cnt); end
      step(2);
   endtask

   task automatic test_rst_button();
      rst_btn_raw = 1'b0;
      step(10);
      tests_run++; if (core_rst_n !== 1'b1) begin tests_failed++; $display("FAIL rstbtn_early: got %b expected 1", core_rst_n); end
      step(1);
      tests_run++; if (core_rst_n !== 1'b0) begin tests_failed++; $display("FAIL rstbtn_fall: got %b expected 0", core_rst_n); end
      step(6);
      tests_run++; if (core_rst_n !== 1'b0) begin tests_failed++; $display("FAIL rstbtn_held: got %b expected 0", core_rst_n); end
      rst_btn_raw = 1'b1;
      step(14);
      tests_run++; if (core_rst_n !== 1'b0) begin tests_failed++; $display("FAIL rstbtn_release_early: got %b expected 0", core_rst_n); end
      step(1);
      tests_run++; if (core_rst_n !== 1'b1) begin tests_failed++; $display("FAIL rstbtn_release: got %b expected 1", core_rst_n); end
      tests_run++; if (lock_loss_cnt !== 8'd1 || btn_level !== 2'b00) begin tests_failed++; $display("FAIL rstbtn_side: got cnt %0d level %b expected 1/00", lock_loss_cnt, btn_level); end
      step(2);
   endtask

   task automatic test_lock_saturate();
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         step(1);
         pll_locked = 1'b1;
         step(9);
         if (i == 9) begin
            tests_run++; if (lock_loss_cnt !== 8'd11) begin tests_failed++; $display("FAIL lock_count_11: got %0d expected 11", lock_loss_cnt); end
         end
      end
      tests_run++; if (lock_loss_cnt !== 8'd255) begin tests_failed++; $display("FAIL lock_saturate: got %0d expected 255", lock_loss_cnt); end
      tests_run++; if (core_rst_n !== 1'b1) begin tests_failed++; $display("FAIL lock_saturate_run: got %b expected 1", core_rst_n); end
   endtask

   task automatic test_async_reset();
      btn_raw[0] = 1'b0;
      step(10);
      tests_run++; if (btn_level !== 2'b01) begin tests_failed++; $display("FAIL async_pre_level: got %b expected 01", btn_level); end
      // start a release debounce and a lock-loss so HOLD is entered
      btn_raw[0] = 1'b1;
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(4);  // edge k+15: in HOLD, release count in progress
      tests_run++; if (core_rst_n !== 1'b0 || btn_level !== 2'b01) begin tests_failed++; $display("FAIL async_pre_hold: got rst_n %b level %b expected 0/01", core_rst_n, btn_level); end
      #3 rst = 1'b1;
      #1;
      tests_run++; if (btn_level !== 2'b00 || btn_press !== 2'b00 || btn_release !== 2'b00) begin tests_failed++; $display("FAIL async_btn: got %b/%b/%b expected 00/00/00", btn_level, btn_press, btn_release); end
      tests_run++; if (core_rst_n !== 1'b0 || lock_loss_cnt !== 8'd0) begin tests_failed++; $display("FAIL async_seq: got rst_n %b cnt %0d expected 0/0", core_rst_n, lock_loss_cnt); end
      step(2);
      rst = 1'b0;
      step(6);
      tests_run++; if (core_rst_n !== 1'b0) begin tests_failed++; $display("FAIL restart_early: got %b expected 0", core_rst_n); end
      step(1);
      tests_run++; if (core_rst_n !== 1'b1 || btn_level !== 2'b00 || lock_loss_cnt !== 8'd0) begin tests_failed++; $display("FAIL restart_run: got rst_n %b level %b cnt %0d expected 1/00/0", core_rst_n, btn_level, lock_loss_cnt); end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_lock_loss();
      test_rst_button();
      test_lock_saturate();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
